uart_tx_fifo: RTL

// - Parametrised UART transmitter with an input FIFO; successor to the fixed 8N1 single-word tx used on icebreaker.
// - Accepts words over valid/ready, buffers up to FIFO_DEPTH of them and serialises back-to-back frames on tx_o.
// - Sits between the ALU result path and the board TX pin; runs from the 25 MHz PLL clock.

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO; UART_TX_PARITY_EN adds a parity bit
module uart_tx_fifo #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        t_valid_i,
  output logic                        t_ready_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, level_d;
  logic              ready_q, push, pop, empty;
  logic [DATA_W-1:0] head;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end, load;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign push      = t_valid_i && ready_q;
  assign empty     = (wr_ptr == rd_ptr);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign pop       = load;
  assign level_o   = wr_ptr - rd_ptr;
  assign t_ready_o = ready_q;
  assign tx_o      = tx_q;
  assign busy_o    = (state_q != IDLE) || (level_o != '0);

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    if (push) wr_ptr_d = wr_ptr + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr + 1'b1;
    level_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  // Bit sequencer; tx_d is the value the line takes for the next clock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (cnt_q == CNT_W'(DIV - 1));
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            if (!empty) load = 1'b1;
            else        state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Pop the head word and start its frame with no idle gap.
    if (load) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = head;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ PARITY_ODD;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      ready_q <= (level_d != FULL_LVL);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
